// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Detects the hazards that bypassing cannot cover (load-use, taken-branch
// redirect, multi-cycle data-memory wait) and drives the pipeline-register
// enables, flushes and bubbles that resolve them. Also keeps saturating
// stall/flush statistics and a sticky memory-timeout flag.
module hazard_stall_unit #(
   parameter int LOAD_BUBBLES = 1,
   parameter int MEM_TIMEOUT  = 255,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IF_ID_rs1,
   input  logic [4:0]       IF_ID_rs2,
   input  logic [4:0]       ID_EX_rd,
   input  logic             ID_EX_mem_read,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             IF_ID_write,
   output logic             IF_ID_flush,
   output logic             ID_EX_bubble,
   output logic             EX_MEM_write,
   output logic             MEM_WB_bubble,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam logic [1:0] ST_RUN        = 2'd0;
   localparam logic [1:0] ST_LOAD_STALL = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT   = 2'd2;

   // Wide enough to hold MEM_TIMEOUT itself so the counter can park there.
   localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

   logic [1:0]       state_q, state_d;
   logic [1:0]       bub_cnt_q, bub_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             load_use;
   logic             mem_wait;
   logic             waiting;
   logic             timeout_hit;

   // x0 is hardwired to zero, so a load targeting it can never create a dependence.
   assign load_use = ID_EX_mem_read && (ID_EX_rd != 5'd0) &&
                     ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));
   assign mem_wait = dmem_req && !dmem_ready;

   // Hazard FSM: Mealy outputs and next state from the current state and hazards.
   always_comb begin
      pc_write      = 1'b1;
      IF_ID_write   = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_bubble  = 1'b0;
      EX_MEM_write  = 1'b1;
      MEM_WB_bubble = 1'b0;
      waiting       = 1'b0;
      state_d       = state_q;
      bub_cnt_d     = bub_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (mem_wait) begin
               pc_write      = 1'b0;
               IF_ID_write   = 1'b0;
               EX_MEM_write  = 1'b0;
               MEM_WB_bubble = 1'b1;
               waiting       = 1'b1;
               state_d       = ST_MEM_WAIT;
            end else if (branch_taken) begin
               // The dependent instruction in decode is squashed, so any load-use is moot.
               IF_ID_flush  = 1'b1;
               ID_EX_bubble = 1'b1;
            end else if (load_use) begin
               pc_write     = 1'b0;
               IF_ID_write  = 1'b0;
               ID_EX_bubble = 1'b1;
               if (LOAD_BUBBLES > 1) begin
                  bub_cnt_d = 2'(LOAD_BUBBLES - 1);
                  state_d   = ST_LOAD_STALL;
               end
            end
         end
         ST_LOAD_STALL: begin
            if (mem_wait) begin
               // Remaining bubbles are held and resumed once memory completes.
               pc_write      = 1'b0;
               IF_ID_write   = 1'b0;
               EX_MEM_write  = 1'b0;
               MEM_WB_bubble = 1'b1;
               waiting       = 1'b1;
               state_d       = ST_MEM_WAIT;
            end else if (branch_taken) begin
               IF_ID_flush  = 1'b1;
               ID_EX_bubble = 1'b1;
               bub_cnt_d    = 2'd0;
               state_d      = ST_RUN;
            end else begin
               pc_write     = 1'b0;
               IF_ID_write  = 1'b0;
               ID_EX_bubble = 1'b1;
               if (bub_cnt_q <= 2'd1) begin
                  bub_cnt_d = 2'd0;
                  state_d   = ST_RUN;
               end else begin
                  bub_cnt_d = bub_cnt_q - 2'd1;
               end
            end
         end
         ST_MEM_WAIT: begin
            // branch_taken is deliberately ignored here; EX holds it until we exit.
            if (!dmem_ready) begin
               pc_write      = 1'b0;
               IF_ID_write   = 1'b0;
               EX_MEM_write  = 1'b0;
               MEM_WB_bubble = 1'b1;
               waiting       = 1'b1;
            end else begin
               state_d = (bub_cnt_q != 2'd0) ? ST_LOAD_STALL : ST_RUN;
            end
         end
         default: begin
            state_d   = ST_RUN;
            bub_cnt_d = 2'd0;
         end
      endcase
   end

   // Wait-length tracking, sticky timeout flag and saturating statistics.
   always_comb begin
      tmo_cnt_d = '0;
      if (waiting) begin
         tmo_cnt_d = tmo_cnt_q;
         if (tmo_cnt_q != TMO_W'(MEM_TIMEOUT)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
         end
      end
      timeout_hit   = waiting && (tmo_cnt_q == TMO_W'(MEM_TIMEOUT - 1));
      mem_timeout_d = mem_timeout_q | timeout_hit;
      stall_d       = stall_q;
      if (!pc_write && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end
      flush_d = flush_q;
      if (IF_ID_flush && (flush_q != '1)) begin
         flush_d = flush_q + CNT_W'(1);
      end
   end

   // State and counter registers; reset aborts any stall in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         bub_cnt_q     <= 2'd0;
         tmo_cnt_q     <= '0;
         mem_timeout_q <= 1'b0;
         stall_q       <= '0;
         flush_q       <= '0;
      end else begin
         state_q       <= state_d;
         bub_cnt_q     <= bub_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_q       <= stall_d;
         flush_q       <= flush_d;
      end
   end

   assign mem_timeout  = mem_timeout_q | timeout_hit;
   assign stall_cycles = stall_q;
   assign flush_events = flush_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit. Two instances share the clock and reset:
// dut_a with one load bubble, dut_b with three. Both use an 8-cycle memory
// timeout and 4-bit statistics so saturation is reachable quickly.
module tb_hazard_stall_unit;

   localparam int CW = 4;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       mem_read;
      logic       branch;
      logic       req;
      logic       ready;
   } in_t;

   typedef struct {
      in_t        stim;
      logic [5:0] exp;
   } vec_t;

   // Output vector order: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble}
   localparam logic [5:0] O_IDLE = 6'b110010;
   localparam logic [5:0] O_LU   = 6'b000110;
   localparam logic [5:0] O_BR   = 6'b111110;
   localparam logic [5:0] O_MW   = 6'b000001;

   logic clk = 1'b0;
   logic rst_n;
   in_t  in_a, in_b;

   logic a_pc, a_ifw, a_flush, a_bub, a_exw, a_mwb, a_tmo;
   logic b_pc, b_ifw, b_flush, b_bub, b_exw, b_mwb, b_tmo;
   logic [CW-1:0] a_stall, a_flushes, b_stall, b_flushes;
   logic [5:0] a_vec, b_vec;

   int checks = 0;
   int errors = 0;

   assign a_vec = {a_pc, a_ifw, a_flush, a_bub, a_exw, a_mwb};
   assign b_vec = {b_pc, b_ifw, b_flush, b_bub, b_exw, b_mwb};

   always #5 clk = ~clk;

   hazard_stall_unit #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(8), .CNT_W(CW)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_rs1(in_a.rs1), .IF_ID_rs2(in_a.rs2), .ID_EX_rd(in_a.rd),
      .ID_EX_mem_read(in_a.mem_read), .branch_taken(in_a.branch),
      .dmem_req(in_a.req), .dmem_ready(in_a.ready),
      .pc_write(a_pc), .IF_ID_write(a_ifw), .IF_ID_flush(a_flush),
      .ID_EX_bubble(a_bub), .EX_MEM_write(a_exw), .MEM_WB_bubble(a_mwb),
      .mem_timeout(a_tmo), .stall_cycles(a_stall), .flush_events(a_flushes)
   );

   hazard_stall_unit #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(8), .CNT_W(CW)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_rs1(in_b.rs1), .IF_ID_rs2(in_b.rs2), .ID_EX_rd(in_b.rd),
      .ID_EX_mem_read(in_b.mem_read), .branch_taken(in_b.branch),
      .dmem_req(in_b.req), .dmem_ready(in_b.ready),
      .pc_write(b_pc), .IF_ID_write(b_ifw), .IF_ID_flush(b_flush),
      .ID_EX_bubble(b_bub), .EX_MEM_write(b_exw), .MEM_WB_bubble(b_mwb),
      .mem_timeout(b_tmo), .stall_cycles(b_stall), .flush_events(b_flushes)
   );

   function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic mr, input logic br, input logic req, input logic rdy);
      mk = {rs1, rs2, rd, mr, br, req, rdy};
   endfunction

   task automatic applyStimulus(input in_t a, input in_t b);
      in_a = a;
      in_b = b;
   endtask

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[10];
   in_t  nop, lu_x5, mw, mw_rdy, br;
   int   exp_stall, exp_flush;

   initial begin
      nop    = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      lu_x5  = mk(5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      mw     = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      mw_rdy = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      br     = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      tbl[0] = '{mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0), O_IDLE};
      tbl[1] = '{mk(5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), O_LU};
      tbl[2] = '{mk(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), O_LU};
      tbl[3] = '{mk(5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), O_IDLE};
      tbl[4] = '{mk(5'd5, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0), O_IDLE};
      tbl[5] = '{mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0), O_BR};
      tbl[6] = '{mk(5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0), O_BR};
      tbl[7] = '{mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1), O_IDLE};
      tbl[8] = '{mk(5'd7, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0), O_IDLE};
      tbl[9] = '{mk(5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1), O_LU};

      // Reset state
      rst_n = 1'b0;
      applyStimulus(nop, nop);
      #12;
      checkOutput("reset a outputs", int'(a_vec), int'(O_IDLE));
      checkOutput("reset b outputs", int'(b_vec), int'(O_IDLE));
      checkOutput("reset a stall", int'(a_stall), 0);
      checkOutput("reset a flush", int'(a_flushes), 0);
      checkOutput("reset a timeout", int'(a_tmo), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single-cycle behaviour from RUN on dut_a
      exp_stall = 0;
      exp_flush = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(tbl[i].stim, nop);
         @(negedge clk);
         checkOutput($sformatf("tbl%0d outputs", i), int'(a_vec), int'(tbl[i].exp));
         checkOutput($sformatf("tbl%0d stall", i), int'(a_stall), exp_stall);
         checkOutput($sformatf("tbl%0d flush", i), int'(a_flushes), exp_flush);
         if (!tbl[i].exp[5]) exp_stall++;
         if (tbl[i].exp[3] && tbl[i].exp[5]) exp_flush++;
         tick();
      end
      applyStimulus(nop, nop);
      @(negedge clk);
      checkOutput("tbl end stall", int'(a_stall), exp_stall);
      checkOutput("tbl end flush", int'(a_flushes), exp_flush);
      tick();

      // Three-bubble load-use on dut_b
      applyStimulus(nop, lu_x5);
      @(negedge clk);
      checkOutput("b lu c0", int'(b_vec), int'(O_LU));
      tick();
      applyStimulus(nop, nop);
      @(negedge clk);
      checkOutput("b lu c1", int'(b_vec), int'(O_LU));
      tick();
      @(negedge clk);
      checkOutput("b lu c2", int'(b_vec), int'(O_LU));
      tick();
      @(negedge clk);
      checkOutput("b lu c3 run", int'(b_vec), int'(O_IDLE));
      checkOutput("b lu stall count", int'(b_stall), 3);
      applyStimulus(nop, mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      checkOutput("b x0 no stall", int'(b_vec), int'(O_IDLE));
      tick();

      // Four-cycle memory wait on dut_a
      for (int i = 0; i < 4; i++) begin
         applyStimulus(mw, nop);
         @(negedge clk);
         checkOutput($sformatf("a mw c%0d", i), int'(a_vec), int'(O_MW));
         tick();
      end
      applyStimulus(mw_rdy, nop);
      @(negedge clk);
      checkOutput("a mw ready", int'(a_vec), int'(O_IDLE));
      checkOutput("a mw stall count", int'(a_stall), 7);
      checkOutput("a mw no timeout", int'(a_tmo), 0);
      tick();

      // Branch held during a memory wait is serviced after exit
      applyStimulus(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0), nop);
      @(negedge clk);
      checkOutput("a br frozen", int'(a_vec), int'(O_MW));
      tick();
      applyStimulus(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1), nop);
      @(negedge clk);
      checkOutput("a br ready cycle", int'(a_vec), int'(O_IDLE));
      tick();
      applyStimulus(br, nop);
      @(negedge clk);
      checkOutput("a br serviced", int'(a_vec), int'(O_BR));
      tick();
      applyStimulus(nop, nop);
      @(negedge clk);
      checkOutput("a br flush count", int'(a_flushes), 3);
      tick();

      // Memory wait preempts a load stall on dut_b, bubbles resume afterwards
      applyStimulus(nop, lu_x5);
      @(negedge clk);
      checkOutput("b pre c0", int'(b_vec), int'(O_LU));
      tick();
      applyStimulus(nop, mw);
      @(negedge clk);
      checkOutput("b pre c1 mw", int'(b_vec), int'(O_MW));
      tick();
      applyStimulus(nop, mw_rdy);
      @(negedge clk);
      checkOutput("b pre c2 ready", int'(b_vec), int'(O_IDLE));
      tick();
      applyStimulus(nop, nop);
      @(negedge clk);
      checkOutput("b pre c3 resume", int'(b_vec), int'(O_LU));
      tick();
      @(negedge clk);
      checkOutput("b pre c4 resume", int'(b_vec), int'(O_LU));
      tick();
      @(negedge clk);
      checkOutput("b pre c5 run", int'(b_vec), int'(O_IDLE));
      checkOutput("b pre stall count", int'(b_stall), 7);
      tick();

      // Branch aborts a load stall on dut_b
      applyStimulus(nop, lu_x5);
      @(negedge clk);
      checkOutput("b abort c0", int'(b_vec), int'(O_LU));
      tick();
      applyStimulus(nop, br);
      @(negedge clk);
      checkOutput("b abort branch", int'(b_vec), int'(O_BR));
      tick();
      applyStimulus(nop, nop);
      @(negedge clk);
      checkOutput("b abort run", int'(b_vec), int'(O_IDLE));
      checkOutput("b abort stall count", int'(b_stall), 8);
      checkOutput("b abort flush count", int'(b_flushes), 1);
      tick();

      // Timeout on the 8th wait cycle; stall counter saturates at 15
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(mw, nop);
         @(negedge clk);
         checkOutput($sformatf("a tmo c%0d", i), int'(a_tmo), (i >= 8) ? 1 : 0);
         tick();
      end
      applyStimulus(mw_rdy, nop);
      @(negedge clk);
      checkOutput("a tmo after ready", int'(a_tmo), 1);
      checkOutput("a stall saturated", int'(a_stall), 15);
      tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(mw, nop);
         tick();
      end
      applyStimulus(mw_rdy, nop);
      tick();
      applyStimulus(nop, nop);
      @(negedge clk);
      checkOutput("a stall still saturated", int'(a_stall), 15);
      checkOutput("a tmo sticky", int'(a_tmo), 1);
      tick();

      // Flush counter saturates at 15
      for (int i = 0; i < 14; i++) begin
         applyStimulus(br, nop);
         tick();
      end
      applyStimulus(nop, nop);
      @(negedge clk);
      checkOutput("a flush saturated", int'(a_flushes), 15);
      tick();

      // Asynchronous reset in the middle of stalls
      applyStimulus(mw, lu_x5);
      @(negedge clk);
      checkOutput("rst pre a mw", int'(a_vec), int'(O_MW));
      tick();
      applyStimulus(mw, nop);
      @(negedge clk);
      checkOutput("rst pre a wait", int'(a_vec), int'(O_MW));
      checkOutput("rst pre b stall", int'(b_vec), int'(O_LU));
      applyStimulus(nop, nop);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst a outputs", int'(a_vec), int'(O_IDLE));
      checkOutput("rst b outputs", int'(b_vec), int'(O_IDLE));
      checkOutput("rst a timeout", int'(a_tmo), 0);
      checkOutput("rst a stall", int'(a_stall), 0);
      checkOutput("rst a flush", int'(a_flushes), 0);
      checkOutput("rst b stall", int'(b_stall), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      checkOutput("post rst a run", int'(a_vec), int'(O_IDLE));
      checkOutput("post rst b run", int'(b_vec), int'(O_IDLE));
      checkOutput("post rst a stall", int'(a_stall), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
